// File: rtl/vec_exec_unit.sv
// Execute stage: 16-lane ALU / reduce, serialised LPC lanes per cycle.
// Optional signed add/sub/reduce saturation via VEXEC_SAT_EN.
module vec_exec_unit #(
  parameter int LPC = 4,
  localparam int NLANES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NLANES-1:0][31:0]  opa,
  input  logic [NLANES-1:0][31:0]  opb,
  input  logic [2:0]               cmd,
  input  logic                     sel_v,
  input  logic [3:0]               dst,
  output logic [NLANES-1:0][31:0]  wd,
  output logic                     we,
  output logic [3:0]               wa,
  output logic                     wsel_v,
  output logic [2:0]               wcmd
);

  localparam int NG = NLANES / LPC;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t state_q, state_d;

  logic [NLANES-1:0][31:0] a_q, b_q, res_q, nres;
  logic [2:0]              c_q;
  logic                    v_q;
  logic [3:0]              d_q;
  logic [4:0]              g_q;
  logic [31:0]             acc_q, nacc;
  logic [3:0]              li;
  logic                    last, red;

  function automatic logic [31:0] add32(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        sub
  );
`ifdef VEXEC_SAT_EN
    logic [32:0] s;
    s = sub ? {a[31], a} - {b[31], b}
            : {a[31], a} + {b[31], b};
    if (s[32] != s[31])
      return s[32] ? 32'h8000_0000 : 32'h7fff_ffff;
    return s[31:0];
`else
    return sub ? a - b : a + b;
`endif
  endfunction

  // cmd 101 lands here as a plain add; vector reduce uses nacc instead
  function automatic logic [31:0] alu(
    input logic [2:0]  c,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [31:0] r;
    r = '0;
    unique case (c)
      3'b000: r = add32(a, b, 1'b0);
      3'b001: r = add32(a, b, 1'b1);
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b100: r = a * b;
      3'b101: r = add32(a, b, 1'b0);
      3'b110: r = a << b[4:0];
      3'b111: r = a ^ b;
    endcase
    return r;
  endfunction

  assign in_ready = (state_q == IDLE);
  assign red      = v_q && (c_q == 3'b101);
  assign last     = !v_q || (g_q == 5'(NG - 1));

  always_comb begin
    nres = res_q;
    nacc = acc_q;
    li   = '0;
    for (int j = 0; j < LPC; j++) begin
      li       = 4'(int'(g_q) * LPC + j);
      nres[li] = alu(c_q, a_q[li], b_q[li]);
      nacc     = add32(nacc, a_q[li], 1'b0);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = EXEC;
      EXEC:    if (last) state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      v_q    <= 1'b0;
      d_q    <= '0;
      g_q    <= '0;
      acc_q  <= '0;
      res_q  <= '0;
      wd     <= '0;
      we     <= 1'b0;
      wa     <= '0;
      wsel_v <= 1'b0;
      wcmd   <= '0;
    end else begin
      we <= 1'b0;
      if (state_q == IDLE && in_valid) begin
        a_q   <= opa;
        b_q   <= opb;
        c_q   <= cmd;
        v_q   <= sel_v;
        d_q   <= dst;
        g_q   <= '0;
        acc_q <= '0;
      end
      if (state_q == EXEC) begin
        if (!v_q) begin
          wd[NLANES-1] <= alu(c_q, a_q[NLANES-1],
                              b_q[NLANES-1]);
        end else begin
          res_q <= nres;
          acc_q <= nacc;
          g_q   <= g_q + 5'd1;
          if (last)
            wd <= red ? {nacc, {(NLANES-1)*32{1'b0}}}
                      : nres;
        end
        if (last) begin
          we     <= 1'b1;
          wa     <= d_q;
          wsel_v <= v_q;
          wcmd   <= c_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_vec_exec_unit.sv
// Bench for vec_exec_unit: directed cases plus random ops vs a lane model.
// Honours VEXEC_SAT_EN in its reference model.
module tb_vec_exec_unit;

  localparam int LPC = 4;
  localparam int NL  = 16;

  typedef logic [NL-1:0][31:0] vec_t;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, sel_v;
  logic       we, wsel_v;
  vec_t       opa, opb, wd;
  logic [2:0] cmd, wcmd;
  logic [3:0] dst, wa;

  int   errs   = 0;
  int   checks = 0;
  vec_t exp_wd;

  always #5 clk = ~clk;

  vec_exec_unit #(.LPC(LPC)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .opa(opa), .opb(opb), .cmd(cmd),
    .sel_v(sel_v), .dst(dst),
    .wd(wd), .we(we), .wa(wa),
    .wsel_v(wsel_v), .wcmd(wcmd)
  );

  task automatic chk(input string tag,
                     input logic [511:0] obs,
                     input logic [511:0] expv);
    checks++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] add_m(
    input logic [31:0] a, input logic [31:0] b,
    input bit sub);
    longint s;
    s = sub ? longint'($signed(a)) - longint'($signed(b))
            : longint'($signed(a)) + longint'($signed(b));
`ifdef VEXEC_SAT_EN
    if (s > 64'sd2147483647)  return 32'h7fff_ffff;
    if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
    return 32'(s);
  endfunction

  function automatic logic [31:0] lane_m(
    input logic [2:0] c, input logic [31:0] a,
    input logic [31:0] b);
    case (c)
      3'd0:    return add_m(a, b, 1'b0);
      3'd1:    return add_m(a, b, 1'b1);
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a * b;
      3'd5:    return add_m(a, b, 1'b0);
      3'd6:    return a << (b % 32);
      default: return a ^ b;
    endcase
  endfunction

  function automatic vec_t model(
    input vec_t a, input vec_t b, input logic [2:0] c,
    input logic s, input vec_t prev);
    vec_t r;
    logic [31:0] sum;
    if (!s) begin
      r = prev;
      r[NL-1] = lane_m(c, a[NL-1], b[NL-1]);
    end else if (c == 3'd5) begin
      sum = 0;
      for (int i = 0; i < NL; i++) sum = add_m(sum, a[i], 1'b0);
      r = '0;
      r[NL-1] = sum;
    end else begin
      for (int i = 0; i < NL; i++) r[i] = lane_m(c, a[i], b[i]);
    end
    return r;
  endfunction

  task automatic scramble();
    for (int i = 0; i < NL; i++) begin
      opa[i] = $urandom;
      opb[i] = $urandom;
    end
    cmd   = 3'($urandom_range(0, 7));
    sel_v = 1'($urandom_range(0, 1));
    dst   = 4'($urandom_range(0, 15));
  endtask

  task automatic run_op(input vec_t a, input vec_t b,
                        input logic [2:0] c, input logic s,
                        input logic [3:0] d, input bit noise,
                        input string tag);
    vec_t expv;
    int   k;
    int   lat;
    @(negedge clk);
    chk({tag, ".ready"}, in_ready, 1'b1);
    opa = a; opb = b; cmd = c; sel_v = s; dst = d;
    in_valid = 1'b1;
    expv = model(a, b, c, s, exp_wd);
    lat  = s ? NL / LPC + 1 : 2;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (noise && !we) scramble();
      else in_valid = 1'b0;
    end while (!we && k < 40);
    in_valid = 1'b0;
    chk({tag, ".lat"}, k, lat);
    chk({tag, ".wd"}, wd, expv);
    chk({tag, ".wa"}, wa, d);
    chk({tag, ".wsel"}, wsel_v, s);
    chk({tag, ".wcmd"}, wcmd, c);
    exp_wd = expv;
    @(negedge clk);
    chk({tag, ".we_pulse"}, we, 1'b0);
    chk({tag, ".ready_after"}, in_ready, 1'b1);
    chk({tag, ".wd_hold"}, wd, expv);
  endtask

  initial begin
    vec_t a, b;
    bit   saw_we;
    rst = 1'b1; in_valid = 1'b0;
    opa = '0; opb = '0; cmd = '0; sel_v = 1'b0; dst = '0;
    exp_wd = '0;
    repeat (3) @(negedge clk);
    chk("rst.we", we, 1'b0);
    chk("rst.wd", wd, '0);
    chk("rst.wa", wa, '0);
    chk("rst.wsel", wsel_v, 1'b0);
    chk("rst.wcmd", wcmd, '0);
    rst = 1'b0;

    for (int i = 0; i < NL; i++) begin
      a[i] = i; b[i] = 2;
    end
    run_op(a, b, 3'd0, 1'b1, 4'd3, 1'b0, "vadd");
    for (int i = 0; i < NL; i++)
      chk("vadd.lane", wd[i], 32'(i + 2));

    for (int i = 0; i < NL; i++) a[i] = 1;
    a[15] = 5; a[0] = 2;
    run_op(a, b, 3'd5, 1'b1, 4'd9, 1'b0, "reduce");
    chk("reduce.sum", wd[15], 32'd21);

    for (int i = 0; i < NL; i++) begin
      a[i] = $urandom; b[i] = $urandom;
    end
    a[15] = 7; b[15] = 5;
    run_op(a, b, 3'd0, 1'b0, 4'd2, 1'b0, "sadd");
    chk("sadd.val", wd[15], 32'd12);
    chk("sadd.keep", wd[14:0], {15{32'd0}});

    for (int i = 0; i < NL; i++) begin
      a[i] = 32'h0001_0000; b[i] = 32'h0001_0000;
    end
    run_op(a, b, 3'd4, 1'b1, 4'd4, 1'b0, "mul");
    chk("mul.zero", wd, '0);

    for (int i = 0; i < NL; i++) begin
      a[i] = 1; b[i] = 33;
    end
    run_op(a, b, 3'd6, 1'b1, 4'd5, 1'b0, "shl");
    chk("shl.l0", wd[0], 32'd2);
    chk("shl.l15", wd[15], 32'd2);

    a[15] = 32'h7fff_ffff; b[15] = 32'd1;
    run_op(a, b, 3'd0, 1'b0, 4'd6, 1'b0, "sat");
`ifdef VEXEC_SAT_EN
    chk("sat.val", wd[15], 32'h7fff_ffff);
`else
    chk("sat.val", wd[15], 32'h8000_0000);
`endif

    // reset during the second EXEC cycle of a vector op
    @(negedge clk);
    opa = a; opb = b; cmd = 3'd0; sel_v = 1'b1; dst = 4'd7;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rmid.we", we, 1'b0);
    chk("rmid.wd", wd, '0);
    chk("rmid.wa", wa, '0);
    chk("rmid.wsel", wsel_v, 1'b0);
    chk("rmid.wcmd", wcmd, '0);
    rst = 1'b0;
    exp_wd = '0;
    saw_we = 1'b0;
    @(negedge clk);
    chk("rmid.ready", in_ready, 1'b1);
    repeat (6) begin
      @(negedge clk);
      if (we) saw_we = 1'b1;
    end
    chk("rmid.no_we", saw_we, 1'b0);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NL; i++) begin
        a[i] = (n % 4 == 0) ? 32'h7fff_fff0 + 32'($urandom_range(0, 31))
                            : $urandom;
        b[i] = $urandom;
      end
      run_op(a, b, 3'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)), 1'b1, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/vec_exec_unit.md
Name: vec_exec_unit

Overview:
- Execute stage directly downstream of the vector/scalar register file.
- Consumes the two 16-lane operand bundles and the scalar/vector select, computes a lane-wise ALU result or a cross-lane reduction, and produces the write-back bundle (data, enable, address, select, cmd) that feeds the register file write port.
- Vector ops are serialised over lane groups to bound adder/multiplier area.

Parameters:
- LPC, 4, lanes processed per EXEC cycle; legal values 1, 2, 4, 8, 16.
- NLANES, 16, lanes per vector; fixed, not overridable.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and command valid.
- in_ready  out  1  unit can accept; high only in IDLE.
- opa  in  16x32  operand A; lane 15 is the scalar lane.
- opb  in  16x32  operand B.
- cmd  in  3  operation code.
- sel_v  in  1  0 = scalar op, 1 = vector op.
- dst  in  4  destination register index.
- wd  out  16x32  write-back data.
- we  out  1  write-enable, one-cycle pulse.
- wa  out  4  write address.
- wsel_v  out  1  write select (0 = scalar file, 1 = vector file).
- wcmd  out  3  cmd forwarded to the write port.

Behaviour:
- Reset: synchronous active-high on clk. Outputs: wd = 0, we = 0, wa = 0, wsel_v = 0, wcmd = 0; state = IDLE.
- Reset mid-operation: the in-flight op is discarded, no we pulse is produced, the accumulator is cleared.
- cmd encoding:
  - 000 add, 001 sub, 010 and, 011 or, 100 mul (low 32 bits), 111 xor.
  - 101 reduce-sum of opa across all 16 lanes.
  - 110 shl: opa << opb[4:0] per lane.
- Arithmetic: all ops wrap modulo 2^32; no flags.
- States: IDLE, EXEC, WB.
- IDLE:
  - in_ready = 1.
  - On in_valid: latch opa, opb, cmd, sel_v, dst; clear the lane-group counter g and the accumulator; go to EXEC.
- EXEC:
  - Scalar (sel_v = 0): compute lane 15 only; one cycle; go to WB. Result in wd[15]; wd[14:0] keep their previous values.
  - Vector non-reduce: each cycle compute lanes g*LPC .. g*LPC+LPC-1 into the result register; g increments. After 16/LPC cycles go to WB.
  - Reduce (cmd 101, sel_v = 1): each cycle add the LPC lanes of group g to a 32-bit accumulator. After 16/LPC cycles go to WB. wd[15] = sum; wd[14:0] = 0.
  - cmd 101 with sel_v = 0: behaves as scalar add.
- WB:
  - Exactly one cycle with we = 1.
  - wa = dst, wsel_v = latched sel_v, wcmd = latched cmd.
  - Next state IDLE.
- Latency: accept at edge T → we high during cycle T + 16/LPC + 1 for vector ops, T + 2 for scalar ops. Back-to-back throughput is one op per (latency + 1) cycles.
- wd holds its value after WB until the next WB.
- Inputs are ignored outside IDLE. No backpressure on the write side: the register file always accepts.

Optional Feature:
- Macro VEXEC_SAT_EN.
- Defined: add/sub (cmd 000/001) saturate as signed 32-bit, clamping to 0x7FFFFFFF / 0x80000000. Reduce also saturates at each accumulation step.
- Undefined: wrap-around, as above; no saturation logic is synthesised.

Test Plan:
- Vector add, LPC = 4: opa lane i = i, opb all 2, dst = 3, sel_v = 1, accepted at cycle 0 → we = 1 only in cycle 5; wd lane i = i+2; wa = 3; wsel_v = 1.
- Reduce: opa lanes {15:5, 14..1:1, 0:2}, cmd 101, sel_v = 1 → wd[15] = 21, wd[14:0] = 0, wcmd = 101, wsel_v = 1.
- Scalar add: opa[15] = 7, opb[15] = 5, sel_v = 0, dst = 2 → we in cycle 2; wd[15] = 12; wsel_v = 0; in_ready back high in cycle 3.
- Mul wrap: opa = opb = 0x00010000 all lanes → wd all lanes 0. shl: opa = 1, opb = 33 → wd = 2, since only opb[4:0] is used.
- Reset mid-op: assert rst in cycle 2 of a vector op → no we pulse, outputs zero next cycle, in_ready = 1 the cycle after rst drops.
- VEXEC_SAT_EN: 0x7FFFFFFF + 1 → 0x7FFFFFFF (with macro), 0x80000000 (without macro).
